// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one operand bit per cycle plus a sign-fix cycle; start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = XLEN'(1) << (XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_result;
  logic             r_busy;
  logic             r_done;

  // Operand signedness and magnitudes at accept
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  assign w_a_sgn = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
  assign w_b_sgn = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign w_a_neg = w_a_sgn & SrcA[XLEN-1];
  assign w_b_neg = w_b_sgn & SrcB[XLEN-1];
  assign w_a_mag = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag = w_b_neg ? -SrcB : SrcB;

  // Divide-by-zero and signed-overflow bypass the iterative datapath
  logic            w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_fast_res;
  assign w_div0     = Funct3[2] & (SrcB == '0);
  assign w_ovf      = Funct3[2] & ~Funct3[0] & (SrcA == MIN_NEG) & (&SrcB);
  assign w_fast     = w_div0 | w_ovf;
  assign w_fast_res = w_div0 ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);

  // Multiply step: r_hi accumulates, r_lo holds the multiplier shifting out
  logic [XLEN:0] w_sum;
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide step: r_hi is the partial remainder, r_lo dividend -> quotient
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_diff  = w_shift[XLEN-1:0] - r_b;

  logic [PW-1:0]   w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quot, w_rem, w_fix_res;
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quot     = r_neg_q ? -r_lo : r_lo;
  assign w_rem      = r_neg_r ? -r_hi : r_hi;
  assign w_fix_res  = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                    : ((r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[PW-1:XLEN]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= Funct3;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= Funct3[2] ? w_a_mag : w_b_mag;
              r_b     <= Funct3[2] ? w_b_mag : w_a_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op[2]) begin
            r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_cnt == CNT_W'(XLEN - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in data width, that executes the eight M-extension operations selected by Funct3. It sits beside the single-cycle ALU in the execute stage. Its start/busy/done handshake lets the controller stall the pipeline while a multi-cycle operation runs. The datapath processes one operand bit per cycle, and signed operations get a final sign-fix cycle.

## Interface
- XLEN, 32, operand/result width; must be ≥ 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- flush  in  1  synchronous abort; takes priority over start
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  XLEN  rs1 operand (multiplicand/dividend)
- SrcB  in  XLEN  rs2 operand (multiplier/divisor)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; Result valid
- Result  out  XLEN  registered result; held until the next done

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - On start=1 and flush=0, latch Funct3, SrcA and SrcB. Later input changes are ignored until the next accept.
  - If a special case applies, go to DONE directly (fast path). Otherwise go to CALC.
- **Operand signs:**
  - SrcA is signed for MULH, MULHSU, DIV and REM.
  - SrcB is signed for MULH, DIV and REM.
  - Both operands are signed for MUL as well; this is harmless because the low XLEN bits are sign-agnostic.
  - Signed operands are converted to magnitudes at accept. Result-negate flags are latched at the same time.
- **CALC, multiply:** shift-add over a 2·XLEN product, one multiplier bit per cycle, XLEN cycles.
- **CALC, divide:** restoring division, one quotient bit per cycle, XLEN cycles.
- **Iteration counter:** width $clog2(XLEN)+1; cleared on accept. CALC exits when the counter reaches XLEN.
- **FIX (1 cycle):**
  - Multiply: negate the 2·XLEN product if exactly one signed operand was negative.
  - Divide: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend was negative.
  - Load Result: MUL takes the product low half. MULH/MULHSU/MULHU take the high half. DIV/DIVU take the quotient. REM/REMU take the remainder.
- **DONE (1 cycle):** done=1, then IDLE unconditionally. start in DONE is ignored.
- **Fast path** (DONE in cycle 1, Result loaded at accept):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - DIV with SrcA = 1<<(XLEN-1) and SrcB = all-ones gives SrcA; the matching REM gives 0.
- **flush:** in any state, returns to IDLE at the next edge. No done pulse; Result is unchanged.
- **start while busy:** ignored, with no effect on the operation in flight.
- **Reset:** state IDLE; busy=0, done=0, Result=0; all internal registers cleared.

## Timing
- Cycle 0 is the edge that samples start in IDLE.
- **Normal path:**
  - CALC covers cycles 1..XLEN; FIX is cycle XLEN+1; DONE is cycle XLEN+2.
  - Latency is 34 cycles for XLEN=32.
  - busy is high in cycles 1..XLEN+2.
  - The next start can be accepted in cycle XLEN+3.
- **Fast path:** busy=1 and done=1 in cycle 1; next accept in cycle 2.
- done and Result are registered outputs, with no combinational path from any input.
- flush sampled at edge n gives busy=0 in cycle n+1.
- rst_n assertion forces the reset values immediately, independent of clk, including mid-operation.

## Test plan
- **MUL** 7 × 0xFFFFFFFD (−3): Result=0xFFFFFFEB. busy=1 in cycles 1–34, done=1 only in cycle 34. Change SrcA in cycle 5; the result must be unchanged.
- **Multiply high halves:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide and remainder:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- **Special cases** (done in cycle 1, busy low in cycle 2):
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Abort and reset:**
  - flush at edge 10 of a DIV: busy=0 in cycle 11, no done, Result keeps its prior value.
  - start pulsed in cycle 5 of a MUL: ignored.
  - rst_n low in cycle 20: busy, done and Result are 0 immediately.
  - After reset, a new MUL 3×4 → 12.
- **XLEN=8 instance:** MULHU 0xFF × 0xFF → 0xFE with done in cycle 10; DIV 0x80 / 0xFF → 0x80 in cycle 1.
